spi_cmd_regfile_module: RTL

//  Parametrised SPI slave command layer. Sits between the SPI byte engine
//  (iDone/iData/oCall/oData) and the fabric. Decodes the first byte of each
//  ncs-low frame as an opcode and serves ID readback plus auto-incrementing

---
 rtl/spi_cmd_regfile_module_if.sv | 11 +
 rtl/spi_cmd_regfile_module.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regfile_module_if.sv
// Byte-engine handshake between the SPI shifter and the command layer.
// The master modport is the byte engine; the slave modport is the command layer.
interface spi_cmd_regfile_module_if;
    logic [1:0] iDone;
    logic [7:0] iData;
    logic       oCall;
    logic [7:0] oData;

    modport master (output iDone, output iData, input oCall, input oData);
    modport slave  (input iDone, input iData, output oCall, output oData);
endinterface

// File: rtl/spi_cmd_regfile_module.sv
// SPI slave command layer: opcode decode, ID readback and auto-incrementing
// burst access to an 8-bit register file. Optional status opcode: SPI_CMD_STATUS_EN.
module spi_cmd_regfile_module #(
    parameter int         NUM_REGS    = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] ID_BYTE     = 8'hD4,
    parameter int         SYNC_STAGES = 3,
    parameter logic [7:0] REG_RST     = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ncs,
    spi_cmd_regfile_module_if.slave bus,
    output logic [NUM_REGS*8-1:0]   oRegs,
    output logic                    oWrStb,
    output logic [ADDR_W-1:0]       oWrAddr,
    output logic [7:0]              oWrData
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_READ   = 3'd4,
        ST_REPLY  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  ncs_sync_r;
    logic                    ncs_t_s;
    logic [7:0]              opcode_r;
    logic                    rd_mode_r;
    logic [ADDR_W-1:0]       ptr_r;
    logic [ADDR_W-1:0]       ptr_next_s;
    logic [ADDR_W-1:0]       addr_in_s;
    logic [7:0]              regs_r [NUM_REGS];
    logic                    call_r;
    logic [7:0]              data_r;
    logic                    wr_stb_r;
    logic [ADDR_W-1:0]       wr_addr_r;
    logic [7:0]              wr_data_r;
    logic                    is_status_op_s;
    logic [7:0]              status_byte_s;

    assign ncs_t_s    = ncs_sync_r[SYNC_STAGES-1];
    assign ptr_next_s = ptr_r + ADDR_W'(1'b1);
    assign addr_in_s  = bus.iData[ADDR_W-1:0];

    assign bus.oCall = call_r;
    assign bus.oData = data_r;
    assign oWrStb    = wr_stb_r;
    assign oWrAddr   = wr_addr_r;
    assign oWrData   = wr_data_r;

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
        assign oRegs[8*g +: 8] = regs_r[g];
    end

`ifdef SPI_CMD_STATUS_EN
    logic [6:0] err_cnt_r;
    logic       bad_op_r;
    logic       bad_op_s;
    logic       status_clr_s;

    assign is_status_op_s = (opcode_r == 8'hAA);
    assign status_byte_s  = {bad_op_r, err_cnt_r};
    assign bad_op_s       = (state_r == ST_DECODE) && !ncs_t_s && !is_status_op_s &&
                            (opcode_r != 8'h06) && (opcode_r != 8'h03) && (opcode_r != 8'h02);
    assign status_clr_s   = (state_r == ST_REPLY) && !ncs_t_s && bus.iDone[1] && is_status_op_s;

    // Unknown-opcode counter and sticky flag, cleared by the status reply that reports them.
    always_ff @(posedge clk) begin
        if (rst || status_clr_s) begin
            err_cnt_r <= 7'd0;
            bad_op_r  <= 1'b0;
        end else if (bad_op_s) begin
            bad_op_r <= 1'b1;
            if (err_cnt_r != 7'd127) begin
                err_cnt_r <= err_cnt_r + 7'd1;
            end
        end
    end
`else
    assign is_status_op_s = 1'b0;
    assign status_byte_s  = 8'h00;
`endif

    // Chip-select synchroniser; resets to deselected.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync_r <= '1;
        end else begin
            ncs_sync_r <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
        end
    end

    // Command FSM with registered byte-engine and write-strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            opcode_r  <= 8'h00;
            rd_mode_r <= 1'b0;
            ptr_r     <= '0;
            call_r    <= 1'b0;
            data_r    <= 8'h00;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= REG_RST;
            end
        end else begin
            wr_stb_r <= 1'b0;
            if (ncs_t_s) begin
                state_r <= ST_IDLE;
                call_r  <= 1'b0;
                data_r  <= 8'h00;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.iDone[0]) begin
                            opcode_r <= bus.iData;
                            state_r  <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        case (opcode_r)
                            8'h06: begin
                                state_r <= ST_REPLY;
                                call_r  <= 1'b1;
                                data_r  <= ID_BYTE;
                            end
                            8'h03: begin
                                rd_mode_r <= 1'b1;
                                state_r   <= ST_ADDR;
                            end
                            8'h02: begin
                                rd_mode_r <= 1'b0;
                                state_r   <= ST_ADDR;
                            end
                            default: begin
                                if (is_status_op_s) begin
                                    state_r <= ST_REPLY;
                                    call_r  <= 1'b1;
                                    data_r  <= status_byte_s;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        endcase
                    end
                    ST_ADDR: begin
                        if (bus.iDone[0]) begin
                            ptr_r <= addr_in_s;
                            if (rd_mode_r) begin
                                state_r <= ST_READ;
                                call_r  <= 1'b1;
                                data_r  <= regs_r[addr_in_s];
                            end else begin
                                state_r <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (bus.iDone[0]) begin
                            regs_r[ptr_r] <= bus.iData;
                            wr_stb_r      <= 1'b1;
                            wr_addr_r     <= ptr_r;
                            wr_data_r     <= bus.iData;
                            ptr_r         <= ptr_next_s;
                        end
                    end
                    ST_READ: begin
                        call_r <= 1'b1;
                        if (bus.iDone[1]) begin
                            ptr_r  <= ptr_next_s;
                            data_r <= regs_r[ptr_next_s];
                        end else begin
                            data_r <= regs_r[ptr_r];
                        end
                    end
                    ST_REPLY: begin
                        if (bus.iDone[1]) begin
                            call_r  <= 1'b0;
                            data_r  <= 8'h00;
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_IGNORE: begin
                        call_r <= 1'b0;
                        data_r <= 8'h00;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        call_r  <= 1'b0;
                        data_r  <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
